// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM refresh scheduler.
package sdram_pkg;

  localparam int unsigned DEBT_W               = 4;
  localparam int unsigned TREFI_CYCLES_DEFAULT = 780;
  localparam int unsigned MAX_DEBT_DEFAULT     = 8;
  localparam int unsigned URGENT_LEVEL_DEFAULT = 6;
  localparam int unsigned CNT_W_DEFAULT        = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAZY   = 2'd1,
    ST_URGENT = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_interval_timer.sv
// Free-running tREFI interval counter; tick marks the last cycle of each interval.
module sdram_interval_timer #(
  parameter int unsigned TREFI_CYCLES = 780,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TREFI_CYCLES - 1);

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// Tracks postponed AUTO REFRESH debt and requests refresh lazily when idle,
// or forcefully once the debt reaches the urgent level.
module sdram_refresh_scheduler
  import sdram_pkg::*;
#(
  parameter int unsigned TREFI_CYCLES = TREFI_CYCLES_DEFAULT,
  parameter int unsigned MAX_DEBT     = MAX_DEBT_DEFAULT,
  parameter int unsigned URGENT_LEVEL = URGENT_LEVEL_DEFAULT,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_idle,
  input  logic              host_busy,
  input  logic              ref_ack,
  input  logic              clear_err,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic [DEBT_W-1:0] debt,
  output logic              overflow_err
);

  localparam logic [DEBT_W-1:0] MAX_L = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] URG_L = DEBT_W'(URGENT_LEVEL);

  logic [CNT_W-1:0]  interval_count;
  logic              tick;
  state_t            state, state_nxt;
  logic [DEBT_W-1:0] debt_nxt;
  logic              ref_req_nxt;
  logic              ref_urgent_nxt;
  logic              overflow_nxt;

  sdram_interval_timer #(
    .TREFI_CYCLES (TREFI_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .count  (interval_count),
    .tick   (tick)
  );

  a_count_in_range : assert property (
    @(posedge clk) disable iff (!rst_n) interval_count < CNT_W'(TREFI_CYCLES)
  );

  // State, debt and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      debt         <= '0;
      ref_req      <= 1'b0;
      ref_urgent   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      debt         <= debt_nxt;
      ref_req      <= ref_req_nxt;
      ref_urgent   <= ref_urgent_nxt;
      overflow_err <= overflow_nxt;
    end
  end

  // Debt update, then state transition from the updated debt.
  always_comb begin
    state_nxt      = state;
    debt_nxt       = debt;
    ref_req_nxt    = 1'b0;
    ref_urgent_nxt = 1'b0;
    overflow_nxt   = overflow_err;

    // Set is evaluated after clear so a saturated tick wins.
    if (clear_err) begin
      overflow_nxt = 1'b0;
    end

    if (!enable) begin
      state_nxt = ST_IDLE;
      debt_nxt  = '0;
    end else begin
      if (tick && !ref_ack) begin
        if (debt == MAX_L) begin
          overflow_nxt = 1'b1;
        end else begin
          debt_nxt = debt + DEBT_W'(1);
        end
      end else if (ref_ack && !tick && (debt != '0)) begin
        debt_nxt = debt - DEBT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (debt_nxt >= URG_L) begin
            state_nxt = ST_URGENT;
          end else if (debt_nxt != '0) begin
            state_nxt = ST_LAZY;
          end
        end
        ST_LAZY: begin
          ref_req_nxt = in_idle && !host_busy;
          if (debt_nxt >= URG_L) begin
            state_nxt = ST_URGENT;
          end else if (debt_nxt == '0) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_URGENT: begin
          ref_req_nxt = 1'b1;
          if (debt_nxt == '0) begin
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase

      // One dead cycle after each issued refresh avoids double-issue.
      if (ref_ack) begin
        ref_req_nxt = 1'b0;
      end
      ref_urgent_nxt = (state_nxt == ST_URGENT);
    end
  end

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Directed vector bench for sdram_refresh_scheduler (TREFI=16, MAX_DEBT=4, URGENT=3).
module tb_sdram_refresh_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       in_idle;
  logic       host_busy;
  logic       ref_ack;
  logic       clear_err;
  logic       ref_req;
  logic       ref_urgent;
  logic [3:0] debt;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       idle;
    logic       busy;
    logic       ack;
    logic       clr;
    int         n;
    logic       req;
    logic       urg;
    logic [3:0] dbt;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  sdram_refresh_scheduler #(
    .TREFI_CYCLES (16),
    .MAX_DEBT     (4),
    .URGENT_LEVEL (3),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_idle      (in_idle),
    .host_busy    (host_busy),
    .ref_ack      (ref_ack),
    .clear_err    (clear_err),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .debt         (debt),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic en, logic idle, logic busy, logic ack, logic clr, int n,
                              logic req, logic urg, logic [3:0] dbt, logic ovf);
    vec_t v;
    v.en = en; v.idle = idle; v.busy = busy; v.ack = ack; v.clr = clr; v.n = n;
    v.req = req; v.urg = urg; v.dbt = dbt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step%0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(int idx, logic req, logic urg, logic [3:0] dbt, logic ovf);
    chk("ref_req", idx, 4'(ref_req), 4'(req));
    chk("ref_urgent", idx, 4'(ref_urgent), 4'(urg));
    chk("debt", idx, debt, dbt);
    chk("overflow_err", idx, 4'(overflow_err), 4'(ovf));
  endtask

  initial begin
    //                en idle busy ack clr   n  req urg debt ovf
    // First tick, lazy request, ack
    vecs.push_back(mk(1, 1, 0, 0, 0, 15, 0, 0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 1, 0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0,  1, 0, 0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 4'd0, 0));
    // Host busy: debt climbs to urgent, then three acks
    vecs.push_back(mk(1, 1, 1, 0, 0, 13, 0, 0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 0, 0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 15, 0, 0, 4'd2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16, 0, 1, 4'd3, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 4'd3, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0,  1, 0, 1, 4'd2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 4'd2, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0,  1, 0, 1, 4'd1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 4'd1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0,  1, 0, 0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 0, 0, 4'd0, 0));
    // Saturation, overflow, clear, clear colliding with saturated tick
    vecs.push_back(mk(1, 1, 1, 0, 0, 57, 1, 1, 4'd4, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 15, 1, 1, 4'd4, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 4'd4, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1,  1, 1, 1, 4'd4, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 14, 1, 1, 4'd4, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1,  1, 1, 1, 4'd4, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 4'd4, 1));
    // Ack coincident with tick at debt 2; ack at debt 0
    vecs.push_back(mk(1, 1, 1, 1, 0,  2, 0, 1, 4'd2, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 12, 1, 1, 4'd2, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0,  1, 0, 1, 4'd2, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1,  2, 0, 0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0,  1, 0, 0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 0, 0, 4'd0, 0));
    // Debt 3 then enable drop; re-enable restarts the interval
    vecs.push_back(mk(1, 1, 0, 0, 0, 44, 1, 1, 4'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 15, 0, 0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 1, 0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 0, 0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 1, 0, 4'd1, 0));

    rst_n = 1'b0; enable = 1'b0; in_idle = 1'b0; host_busy = 1'b0;
    ref_ack = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all(-1, 0, 0, 4'd0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all(0, 0, 0, 4'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      enable    = vecs[i].en;
      in_idle   = vecs[i].idle;
      host_busy = vecs[i].busy;
      ref_ack   = vecs[i].ack;
      clear_err = vecs[i].clr;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      chk_all(i + 1, vecs[i].req, vecs[i].urg, vecs[i].dbt, vecs[i].ovf);
    end

    // Async reset mid-count with a pending ack: clears without a clock edge
    ref_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(100, 0, 0, 4'd0, 0);
    @(negedge clk);
    ref_ack = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    chk_all(101, 0, 0, 4'd0, 0);
    repeat (14) @(posedge clk);
    #1;
    chk_all(102, 0, 0, 4'd0, 0);
    @(posedge clk);
    #1;
    chk_all(103, 0, 0, 4'd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
